mem_lipo_2p_pp: RTL and testbench

Parametrised, ping-pong successor to the single-port line-in/parallel-out pixel buffers.
- Producer side writes whole pixel lines into one page while the consumer reads the other page.
- Reads are either horizontal (one full line) or vertical (one 8-pixel column segment from BANKS consecutive lines), made conflict-free by skewed bank storage.
- Sits between the fetch/reconstruction line writers and the transform/filter engines that need row or column access.

---
 rtl/mem_lipo_2p_pp.sv | 112 +++++++++++
 tb/tb_mem_lipo_2p_pp.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_lipo_2p_pp.sv
// mem_lipo_2p_pp: ping-pong line-in buffer with skewed banks for row or column reads.
// Ports: clk, rst (sync, active-high);
//   a_*: line writer (wen/addr/wdata write one line, done closes the page, rdy = write page empty);
//   b_*: reader (ren/mode/addr/seg issue a row or column read, done releases the page,
//        rdy = read page full, valid/rdata = read result two cycles after the request);
//   err_o: one-cycle pulse after a dropped request or a misaligned column read.
module mem_lipo_2p_pp #(
    parameter int PIXEL_WIDTH = 8,
    parameter int BANKS = 4,
    parameter int ROWS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic a_wen_i,
    input  logic [$clog2(ROWS)-1:0] a_addr_i,
    input  logic [PIXEL_WIDTH*BANKS*8-1:0] a_wdata_i,
    input  logic a_done_i,
    output logic a_rdy_o,
    input  logic b_ren_i,
    input  logic b_mode_i,
    input  logic [$clog2(ROWS)-1:0] b_addr_i,
    input  logic [$clog2(BANKS)-1:0] b_seg_i,
    input  logic b_done_i,
    output logic b_rdy_o,
    output logic b_valid_o,
    output logic [PIXEL_WIDTH*BANKS*8-1:0] b_rdata_o,
    output logic err_o
);
    localparam int LINE_PIX = BANKS * 8;
    localparam int AW = $clog2(ROWS);
    localparam int SW = $clog2(BANKS);
    localparam int SEGW = 8 * PIXEL_WIDTH;
    localparam int DW = PIXEL_WIDTH * LINE_PIX;

    logic [1:0] full_q, full_d;
    logic wp_q, wp_d, rp_q, rp_d;
    logic [SW-1:0] rot_q, rot_d;
    logic v1_q, v1_d, v2_q, v2_d, err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d, mux;
    logic we, re;
    logic [AW-1:0] r0;
    logic [SEGW-1:0] seg_in [BANKS];
    logic [SEGW-1:0] ram_q [BANKS];

    assign a_rdy_o = !full_q[wp_q];
    assign b_rdy_o = full_q[rp_q];
    assign we = a_wen_i & a_rdy_o;
    assign re = b_ren_i & b_rdy_o;
    // column reads always start on a BANKS-aligned line
    assign r0 = b_mode_i ? (b_addr_i & ~AW'(BANKS - 1)) : b_addr_i;

    for (genvar s = 0; s < BANKS; s++) begin : g_seg
        assign seg_in[s] = a_wdata_i[DW-1-s*SEGW -: SEGW];
        // rot_q is the rotation captured with the RAM read, so it matches ram_q
        assign mux[DW-1-s*SEGW -: SEGW] = ram_q[SW'(s) + rot_q];
    end

    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        logic [SEGW-1:0] mem [2*ROWS];
        logic [SW-1:0] off;
        logic [AW:0] raddr;
        logic [SEGW-1:0] ram_d;
        // bank k holds segment (k - row) of each line; in column mode it serves line r0 + (k - seg)
        assign off = SW'(k) - b_seg_i;
        assign raddr = {rp_q, r0 + (b_mode_i ? AW'(off) : AW'(0))};
        assign ram_d = mem[raddr];
        always_ff @(posedge clk) begin
            if (we) mem[{wp_q, a_addr_i}] <= seg_in[SW'(k) - a_addr_i[SW-1:0]];
            if (re) ram_q[k] <= ram_d;
        end
    end

    always_comb begin
        full_d = full_q;
        if (a_done_i && a_rdy_o) full_d[wp_q] = 1'b1;
        if (b_done_i && b_rdy_o) full_d[rp_q] = 1'b0;
        wp_d = wp_q ^ (a_done_i & a_rdy_o);
        rp_d = rp_q ^ (b_done_i & b_rdy_o);
        rot_d = re ? (b_mode_i ? b_seg_i : b_addr_i[SW-1:0]) : rot_q;
        v1_d = re;
        v2_d = v1_q;
        rdata_d = v1_q ? mux : rdata_q;
        err_d = ((a_wen_i | a_done_i) & !a_rdy_o) | ((b_ren_i | b_done_i) & !b_rdy_o)
              | (b_ren_i & b_mode_i & (|b_addr_i[SW-1:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            wp_q <= 1'b0;
            rp_q <= 1'b0;
            rot_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            full_q <= full_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            rot_q <= rot_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign b_valid_o = v2_q;
    assign b_rdata_o = rdata_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_mem_lipo_2p_pp.sv
// tb_mem_lipo_2p_pp: directed plus random checks of mem_lipo_2p_pp against a line-array page model.
module tb_mem_lipo_2p_pp;
    localparam int PW = 8;
    localparam int BANKS = 4;
    localparam int ROWS = 32;
    localparam int AW = 5;
    localparam int DW = PW * BANKS * 8;
    localparam int SEGW = 8 * PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_wen_i = 1'b0, a_done_i = 1'b0, b_ren_i = 1'b0, b_mode_i = 1'b0, b_done_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [1:0] b_seg_i = '0;
    logic [DW-1:0] a_wdata_i = '0;
    logic a_rdy_o, b_rdy_o, b_valid_o, err_o;
    logic [DW-1:0] b_rdata_o;

    logic [DW-1:0] mm [2][ROWS];
    bit m_full [2];
    bit m_wp, m_rp, p_v;
    logic [DW-1:0] p_d, last_d, cx;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_lipo_2p_pp #(.PIXEL_WIDTH(PW), .BANKS(BANKS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst),
        .a_wen_i(a_wen_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_done_i(a_done_i),
        .a_rdy_o(a_rdy_o),
        .b_ren_i(b_ren_i), .b_mode_i(b_mode_i), .b_addr_i(b_addr_i), .b_seg_i(b_seg_i),
        .b_done_i(b_done_i), .b_rdy_o(b_rdy_o), .b_valid_o(b_valid_o), .b_rdata_o(b_rdata_o),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] line_xy(input int y);
        logic [DW-1:0] l;
        l = '0;
        for (int x = 0; x < BANKS * 8; x++) l[DW-1-x*PW -: PW] = PW'(x + y);
        return l;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] l;
        l = '0;
        for (int w = 0; w < DW / 32; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // row mode returns the stored line; column mode stacks segment seg of lines r0..r0+BANKS-1
    function automatic logic [DW-1:0] exp_read(input bit pg, input bit md, input int addr, input int seg);
        logic [DW-1:0] r, line;
        int r0;
        r = '0;
        r0 = addr - addr % BANKS;
        if (!md) return mm[pg][addr];
        for (int i = 0; i < BANKS; i++) begin
            line = mm[pg][r0 + i];
            r[DW-1-i*SEGW -: SEGW] = line[DW-1-seg*SEGW -: SEGW];
        end
        return r;
    endfunction

    task automatic cyc(input bit wen, input int wa, input logic [DW-1:0] wd, input bit ad,
                       input bit ren, input bit md, input int ra, input int sg, input bit bd);
        bit ardy, brdy, ee, re;
        logic [DW-1:0] rd;
        ardy = !m_full[m_wp];
        brdy = m_full[m_rp];
        a_wen_i = wen; a_addr_i = AW'(wa); a_wdata_i = wd; a_done_i = ad;
        b_ren_i = ren; b_mode_i = md; b_addr_i = AW'(ra); b_seg_i = 2'(sg); b_done_i = bd;
        ee = ((wen || ad) && !ardy) || ((ren || bd) && !brdy) || (ren && md && (ra % BANKS != 0));
        re = ren && brdy;
        rd = re ? exp_read(m_rp, md, ra, sg) : '0;
        @(posedge clk);
        #1;
        if (wen && ardy) mm[m_wp][wa] = wd;
        if (ad && ardy) begin m_full[m_wp] = 1'b1; m_wp = !m_wp; end
        if (bd && brdy) begin m_full[m_rp] = 1'b0; m_rp = !m_rp; end
        if (p_v) last_d = p_d;
        chk("b_valid", DW'(b_valid_o), DW'(p_v));
        chk("b_rdata", b_rdata_o, last_d);
        chk("err", DW'(err_o), DW'(ee));
        chk("a_rdy", DW'(a_rdy_o), DW'(!m_full[m_wp]));
        chk("b_rdy", DW'(b_rdy_o), DW'(m_full[m_rp]));
        p_v = re;
        p_d = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        a_wen_i = 0; a_done_i = 0; b_ren_i = 0; b_done_i = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_full[0] = 0; m_full[1] = 0; m_wp = 0; m_rp = 0; p_v = 0; last_d = '0;
        chk("rst_b_valid", DW'(b_valid_o), DW'(0));
        chk("rst_b_rdata", b_rdata_o, '0);
        chk("rst_err", DW'(err_o), DW'(0));
        chk("rst_a_rdy", DW'(a_rdy_o), DW'(1));
        chk("rst_b_rdy", DW'(b_rdy_o), DW'(0));
    endtask

    initial begin
        do_reset();
        for (int y = 0; y < ROWS; y++) cyc(1, y, line_xy(y), 0, 0, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0, 0, 0, 0);
        for (int y = 0; y < ROWS; y++) cyc(0, 0, '0, 0, 1, 0, y, 0, 0);
        idle(2);
        chk("row31_direct", b_rdata_o, line_xy(31));
        cx = '0;
        for (int i = 0; i < BANKS; i++)
            for (int j = 0; j < 8; j++) cx[DW-1-(i*8+j)*PW -: PW] = PW'(16 + j + 4 + i);
        cyc(0, 0, '0, 0, 1, 1, 4, 2, 0);
        cyc(0, 0, '0, 0, 1, 1, 5, 2, 0);
        chk("col4_direct", b_rdata_o, cx);
        idle(1);
        chk("col5_direct", b_rdata_o, cx);
        idle(1);
        for (int y = 0; y < ROWS; y++)
            cyc(1, y, rand_line(), 0, 1, $urandom_range(0, 1), $urandom_range(0, ROWS - 1),
                $urandom_range(0, BANKS - 1), 0);
        cyc(0, 0, '0, 1, 1, 0, 7, 0, 1);
        for (int i = 0; i < 40; i++)
            cyc(0, 0, '0, 0, 1, $urandom_range(0, 1), $urandom_range(0, ROWS - 1),
                $urandom_range(0, BANKS - 1), 0);
        for (int y = 0; y < 4; y++) cyc(1, y, rand_line(), 0, 0, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0, 0, 0, 0);
        cyc(1, 9, rand_line(), 0, 0, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 9, 0, 0);
        idle(2);
        cyc(0, 0, '0, 0, 1, 0, 3, 0, 0);
        cyc(0, 0, '0, 0, 1, 1, 8, 1, 0);
        cyc(0, 0, '0, 0, 1, 0, 20, 0, 0);
        do_reset();
        cyc(0, 0, '0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, '0, 0, 1, 0, 3, 0, 0);
        idle(2);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, ROWS - 1), rand_line(), $urandom_range(0, 7) == 0,
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, ROWS - 1),
                $urandom_range(0, BANKS - 1), $urandom_range(0, 7) == 0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
